pwm_cfg_sequencer: RTL and testbench

Register-bus master that programs the PWM register block with a complete, glitch-safe configuration. On a start request it latches a configuration set, disables the PWM, writes prescaler/ARR/CCR1/CCR2, optionally reads each back to verify, and re-enables the PWM last. It sits between the host-side control logic and the PWM register file, owning that file's write/read port.

---
 rtl/pwm_cfg_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_pwm_cfg_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_cfg_sequencer
//  Purpose  : Register-bus master that programs the PWM register block with a
//             complete configuration: PWM off, PSC/ARR/CCR1/CCR2 writes,
//             optional readback verification, then PWM enable written last.
//  Revision : 1.0  initial release
// ============================================================================
module pwm_cfg_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             verify,
  input  logic             cfg_en,
  input  logic             cfg_mode,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_duty1,
  input  logic [WIDTH-1:0] cfg_duty2,
  input  logic [WIDTH-1:0] cfg_presc,
  output logic             reg_wr_en,
  output logic             reg_rd_en,
  output logic [3:0]       reg_addr,
  output logic [WIDTH-1:0] reg_wr_data,
  input  logic [WIDTH-1:0] reg_rd_data,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err_code,
  output logic [3:0]       err_addr
);

  // Register map
  localparam logic [3:0] ADDR_CTRL = 4'h0;
  localparam logic [3:0] ADDR_ARR  = 4'h4;
  localparam logic [3:0] ADDR_CCR1 = 4'h8;
  localparam logic [3:0] ADDR_CCR2 = 4'hC;
  localparam logic [3:0] ADDR_PSC  = 4'hE;

  // Error codes
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_REJECT   = 2'd1;
  localparam logic [1:0] ERR_MISMATCH = 2'd2;

  // Sequencer states; each bus-access state lasts exactly one cycle
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_REJECT = 4'd1;
  localparam logic [3:0] S_W_OFF  = 4'd2;
  localparam logic [3:0] S_W_PSC  = 4'd3;
  localparam logic [3:0] S_W_ARR  = 4'd4;
  localparam logic [3:0] S_W_CCR1 = 4'd5;
  localparam logic [3:0] S_W_CCR2 = 4'd6;
  localparam logic [3:0] S_R_PSC  = 4'd7;
  localparam logic [3:0] S_R_ARR  = 4'd8;
  localparam logic [3:0] S_R_CCR1 = 4'd9;
  localparam logic [3:0] S_R_CCR2 = 4'd10;
  localparam logic [3:0] S_W_CTRL = 4'd11;
  localparam logic [3:0] S_R_CTRL = 4'd12;
  localparam logic [3:0] S_FAIL   = 4'd13;
  localparam logic [3:0] S_DONE   = 4'd14;

  logic [3:0]       state_q,  state_d;
  logic             verify_q;
  logic             en_q;
  logic             mode_q;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] duty1_q;
  logic [WIDTH-1:0] duty2_q;
  logic [WIDTH-1:0] presc_q;
  logic [1:0]       err_code_q, err_code_d;
  logic [3:0]       err_addr_q, err_addr_d;
  logic             latch_cfg;

  logic [WIDTH-1:0] ctrl_off;
  logic [WIDTH-1:0] ctrl_on;
  logic [WIDTH-1:0] rd_expect;
  logic             rd_mismatch;

  // CTRL word: bit1 = mode, bit0 = enable
  assign ctrl_off = {{(WIDTH-2){1'b0}}, mode_q, 1'b0};
  assign ctrl_on  = {{(WIDTH-2){1'b0}}, mode_q, en_q};

  // Bus outputs decoded purely from the current state (Moore)
  always_comb begin
    reg_wr_en   = 1'b0;
    reg_rd_en   = 1'b0;
    reg_addr    = ADDR_CTRL;
    reg_wr_data = '0;
    rd_expect   = '0;
    case (state_q)
      S_W_OFF:  begin reg_wr_en = 1'b1; reg_addr = ADDR_CTRL; reg_wr_data = ctrl_off; end
      S_W_PSC:  begin reg_wr_en = 1'b1; reg_addr = ADDR_PSC;  reg_wr_data = presc_q;  end
      S_W_ARR:  begin reg_wr_en = 1'b1; reg_addr = ADDR_ARR;  reg_wr_data = period_q; end
      S_W_CCR1: begin reg_wr_en = 1'b1; reg_addr = ADDR_CCR1; reg_wr_data = duty1_q;  end
      S_W_CCR2: begin reg_wr_en = 1'b1; reg_addr = ADDR_CCR2; reg_wr_data = duty2_q;  end
      S_R_PSC:  begin reg_rd_en = 1'b1; reg_addr = ADDR_PSC;  rd_expect   = presc_q;  end
      S_R_ARR:  begin reg_rd_en = 1'b1; reg_addr = ADDR_ARR;  rd_expect   = period_q; end
      S_R_CCR1: begin reg_rd_en = 1'b1; reg_addr = ADDR_CCR1; rd_expect   = duty1_q;  end
      S_R_CCR2: begin reg_rd_en = 1'b1; reg_addr = ADDR_CCR2; rd_expect   = duty2_q;  end
      S_W_CTRL: begin reg_wr_en = 1'b1; reg_addr = ADDR_CTRL; reg_wr_data = ctrl_on;  end
      S_R_CTRL: begin reg_rd_en = 1'b1; reg_addr = ADDR_CTRL; rd_expect   = ctrl_on;  end
      S_FAIL:   begin reg_wr_en = 1'b1; reg_addr = ADDR_CTRL; reg_wr_data = ctrl_off; end
      default:  ;
    endcase
  end

  assign rd_mismatch = reg_rd_en && (reg_rd_data != rd_expect);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign err_code    = err_code_q;
  assign err_addr    = err_addr_q;

  // Next-state, configuration capture and error bookkeeping
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    err_addr_d = err_addr_q;
    latch_cfg  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          latch_cfg  = 1'b1;
          err_addr_d = 4'h0;
          // The inputs seen here are exactly the values being latched, so the
          // duty-vs-period check is decided at acceptance.
          if ((cfg_duty1 > cfg_period) || (cfg_duty2 > cfg_period)) begin
            state_d    = S_REJECT;
            err_code_d = ERR_REJECT;
          end else begin
            state_d    = S_W_OFF;
            err_code_d = ERR_NONE;
          end
        end
      end
      S_REJECT: state_d = S_DONE;
      S_W_OFF:  state_d = S_W_PSC;
      S_W_PSC:  state_d = S_W_ARR;
      S_W_ARR:  state_d = S_W_CCR1;
      S_W_CCR1: state_d = S_W_CCR2;
      S_W_CCR2: state_d = verify_q ? S_R_PSC : S_W_CTRL;
      S_R_PSC:  state_d = S_R_ARR;
      S_R_ARR:  state_d = S_R_CCR1;
      S_R_CCR1: state_d = S_R_CCR2;
      S_R_CCR2: state_d = S_W_CTRL;
      S_W_CTRL: state_d = verify_q ? S_R_CTRL : S_DONE;
      S_R_CTRL: state_d = S_DONE;
      S_FAIL:   state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // First readback mismatch aborts the sequence and forces the PWM off
    if (rd_mismatch) begin
      state_d    = S_FAIL;
      err_code_d = ERR_MISMATCH;
      err_addr_d = reg_addr;
    end
  end

  // State and error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      err_code_q <= ERR_NONE;
      err_addr_q <= 4'h0;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Configuration snapshot taken when a start is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      verify_q <= 1'b0;
      en_q     <= 1'b0;
      mode_q   <= 1'b0;
      period_q <= '0;
      duty1_q  <= '0;
      duty2_q  <= '0;
      presc_q  <= '0;
    end else if (latch_cfg) begin
      verify_q <= verify;
      en_q     <= cfg_en;
      mode_q   <= cfg_mode;
      period_q <= cfg_period;
      duty1_q  <= cfg_duty1;
      duty2_q  <= cfg_duty2;
      presc_q  <= cfg_presc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_cfg_sequencer
//  Purpose  : Self-checking bench for pwm_cfg_sequencer with a register-file
//             model and a transaction-list reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pwm_cfg_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        verify;
  logic        cfg_en;
  logic        cfg_mode;
  logic [15:0] cfg_period;
  logic [15:0] cfg_duty1;
  logic [15:0] cfg_duty2;
  logic [15:0] cfg_presc;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [3:0]  reg_addr;
  logic [15:0] reg_wr_data;
  logic [15:0] reg_rd_data;
  logic        busy;
  logic        done;
  logic [1:0]  err_code;
  logic [3:0]  err_addr;

  int checks = 0;
  int errors = 0;

  pwm_cfg_sequencer #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .verify     (verify),
    .cfg_en     (cfg_en),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .cfg_duty1  (cfg_duty1),
    .cfg_duty2  (cfg_duty2),
    .cfg_presc  (cfg_presc),
    .reg_wr_en  (reg_wr_en),
    .reg_rd_en  (reg_rd_en),
    .reg_addr   (reg_addr),
    .reg_wr_data(reg_wr_data),
    .reg_rd_data(reg_rd_data),
    .busy       (busy),
    .done       (done),
    .err_code   (err_code),
    .err_addr   (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PWM register file model (not reset by the sequencer's reset)
  logic [15:0] regs [16];
  logic [3:0]  corrupt_addr;   // 0xF = no corruption
  always @(posedge clk) if (reg_wr_en) regs[reg_addr] <= reg_wr_data;
  always_comb begin
    reg_rd_data = 16'h0;
    if (reg_rd_en)
      reg_rd_data = regs[reg_addr] ^ ((reg_addr == corrupt_addr) ? 16'h0100 : 16'h0000);
  end

  // One expected bus cycle
  typedef struct {
    logic        wr;
    logic        rd;
    logic [3:0]  addr;
    logic [15:0] data;
    logic        dn;
    logic [1:0]  ec;
    logic [3:0]  ea;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic wr, input logic rd, input logic [3:0] a, input logic [15:0] d,
                      input logic dn, input logic [1:0] ec, input logic [3:0] ea);
    exp_t e;
    e.wr = wr; e.rd = rd; e.addr = a; e.data = d; e.dn = dn; e.ec = ec; e.ea = ea;
    exp_q.push_back(e);
  endtask

  // Reference model: the list of bus cycles that should follow an accepted start
  task automatic build_expected(input logic vrf, input logic en, input logic mode,
                                input logic [15:0] per, input logic [15:0] d1,
                                input logic [15:0] d2, input logic [15:0] ps,
                                input logic [3:0] corr);
    logic [3:0]  wa [5];
    logic [15:0] wd [5];
    logic [15:0] off, on;
    logic        failed;
    logic [3:0]  fa;
    exp_q.delete();
    off = {14'h0, mode, 1'b0};
    on  = {14'h0, mode, en};
    if (d1 > per || d2 > per) begin
      push(0, 0, 4'h0, 16'h0, 0, 2'd1, 4'h0);
      push(0, 0, 4'h0, 16'h0, 1, 2'd1, 4'h0);
      return;
    end
    wa[0] = 4'h0; wd[0] = off;
    wa[1] = 4'hE; wd[1] = ps;
    wa[2] = 4'h4; wd[2] = per;
    wa[3] = 4'h8; wd[3] = d1;
    wa[4] = 4'hC; wd[4] = d2;
    for (int i = 0; i < 5; i++) push(1, 0, wa[i], wd[i], 0, 2'd0, 4'h0);
    failed = 1'b0;
    fa     = 4'h0;
    if (vrf) begin
      for (int i = 1; i < 5 && !failed; i++) begin
        push(0, 1, wa[i], 16'h0, 0, 2'd0, 4'h0);
        if (wa[i] == corr) begin failed = 1'b1; fa = wa[i]; end
      end
    end
    if (!failed) begin
      push(1, 0, 4'h0, on, 0, 2'd0, 4'h0);
      if (vrf) begin
        push(0, 1, 4'h0, 16'h0, 0, 2'd0, 4'h0);
        if (corr == 4'h0) begin failed = 1'b1; fa = 4'h0; end
      end
    end
    if (failed) begin
      push(1, 0, 4'h0, off, 0, 2'd2, fa);
      push(0, 0, 4'h0, 16'h0, 1, 2'd2, fa);
    end else begin
      push(0, 0, 4'h0, 16'h0, 1, 2'd0, 4'h0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".outs"}, {reg_wr_en, reg_rd_en, reg_addr, reg_wr_data, busy, done, err_code, err_addr}, 32'h0);
  endtask

  // Runs one accepted sequence; pulse_ign re-pulses start at k+3 and in the
  // done cycle with scrambled inputs; rst_at >= 0 asserts reset in that cycle index.
  task automatic run_seq(input string tag, input logic vrf, input logic en, input logic mode,
                         input logic [15:0] per, input logic [15:0] d1, input logic [15:0] d2,
                         input logic [15:0] ps, input logic [3:0] corr,
                         input logic pulse_ign, input int rst_at);
    int   n;
    logic ok;
    build_expected(vrf, en, mode, per, d1, d2, ps, corr);
    corrupt_addr = corr;
    verify = vrf; cfg_en = en; cfg_mode = mode;
    cfg_period = per; cfg_duty1 = d1; cfg_duty2 = d2; cfg_presc = ps;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = exp_q.size();
    for (int c = 0; c < n; c++) begin
      if (pulse_ign && (c == 2 || c == n - 1)) begin
        start      = 1'b1;
        verify     = ~vrf;
        cfg_en     = ~en;
        cfg_period = 16'($urandom);
        cfg_duty1  = 16'($urandom);
        cfg_duty2  = 16'($urandom);
        cfg_presc  = 16'($urandom);
      end
      if (c == rst_at) begin
        #2 rst_n = 1'b0;
        #1 chk_all_zero({tag, ".rst"});
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_all_zero({tag, ".post_rst"});
        return;
      end
      chk({tag, ".wr"},   reg_wr_en,   exp_q[c].wr);
      chk({tag, ".rd"},   reg_rd_en,   exp_q[c].rd);
      chk({tag, ".addr"}, reg_addr,    exp_q[c].addr);
      chk({tag, ".data"}, reg_wr_data, exp_q[c].data);
      chk({tag, ".busy"}, busy,        1'b1);
      chk({tag, ".done"}, done,        exp_q[c].dn);
      chk({tag, ".ec"},   err_code,    exp_q[c].ec);
      chk({tag, ".ea"},   err_addr,    exp_q[c].ea);
      tick();
      start = 1'b0;
    end
    chk({tag, ".idle_busy"}, busy, 1'b0);
    chk({tag, ".idle_done"}, done, 1'b0);
    chk({tag, ".idle_ec"},   err_code, exp_q[n-1].ec);
    ok = (exp_q[n-1].ec == 2'd0);
    if (ok) begin
      chk({tag, ".rf_psc"},  regs[4'hE], ps);
      chk({tag, ".rf_arr"},  regs[4'h4], per);
      chk({tag, ".rf_ccr1"}, regs[4'h8], d1);
      chk({tag, ".rf_ccr2"}, regs[4'hC], d2);
      chk({tag, ".rf_ctrl"}, regs[4'h0], {14'h0, mode, en});
    end else if (exp_q[n-1].ec == 2'd2) begin
      chk({tag, ".rf_ctrl_off"}, regs[4'h0], {14'h0, mode, 1'b0});
    end
  endtask

  initial begin
    int          iter_per;
    logic [15:0] p, a, b;
    logic [3:0]  cs;
    logic [3:0]  corr_tbl [5];
    corr_tbl[0] = 4'h0; corr_tbl[1] = 4'h4; corr_tbl[2] = 4'h8;
    corr_tbl[3] = 4'hC; corr_tbl[4] = 4'hE;
    for (int i = 0; i < 16; i++) regs[i] = 16'h0;
    corrupt_addr = 4'hF;
    rst_n = 1'b0; start = 1'b0; verify = 1'b0; cfg_en = 1'b0; cfg_mode = 1'b0;
    cfg_period = 16'h0; cfg_duty1 = 16'h0; cfg_duty2 = 16'h0; cfg_presc = 16'h0;
    #1 chk_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_all_zero("idle");

    // Directed plan
    run_seq("vrf_full",  1, 1, 1, 16'd1000, 16'd250, 16'd750, 16'd7, 4'hF, 0, -1);
    run_seq("novrf",     0, 1, 1, 16'd1000, 16'd250, 16'd750, 16'd7, 4'hF, 0, -1);
    run_seq("reject",    1, 1, 1, 16'd1000, 16'd250, 16'd1001, 16'd7, 4'hF, 0, -1);
    run_seq("bad_arr",   1, 1, 1, 16'd1000, 16'd250, 16'd750, 16'd7, 4'h4, 0, -1);
    run_seq("ignore",    1, 0, 1, 16'd500,  16'd500, 16'd0,   16'd3, 4'hF, 1, -1);
    run_seq("rst_ccr1",  1, 1, 0, 16'd900,  16'd100, 16'd200, 16'd1, 4'hF, 0, 3);
    run_seq("after_rst", 1, 1, 0, 16'd900,  16'd100, 16'd200, 16'd1, 4'hF, 0, -1);
    run_seq("bad_ctrl",  1, 1, 1, 16'd10,   16'd10,  16'd10,  16'd0, 4'h0, 0, -1);

    // Randomized sequences
    for (int it = 0; it < 40; it++) begin
      logic rb;
      rb = ($urandom_range(0, 5) == 0);
      iter_per = int'($urandom_range(0, rb ? 65534 : 65535));
      p = 16'(iter_per);
      a = 16'($urandom_range(0, iter_per));
      b = 16'($urandom_range(0, iter_per));
      if (rb) begin
        if ($urandom_range(0, 1) == 0) a = 16'($urandom_range(iter_per + 1, 65535));
        else                           b = 16'($urandom_range(iter_per + 1, 65535));
      end
      cs = ($urandom_range(0, 3) == 0) ? corr_tbl[$urandom_range(0, 4)] : 4'hF;
      run_seq("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), p, a, b, 16'($urandom), cs,
              1'($urandom_range(0, 1)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
